// File: rtl/workboy_pkg.sv
// Shared constants, link modes and helpers for the WorkBoy serial-link core.
package workboy_pkg;

  localparam logic [7:0] CMD_R          = 8'h52;
  localparam logic [7:0] CMD_W          = 8'h57;
  localparam logic [7:0] CMD_O          = 8'h4F;
  localparam logic [7:0] RESP_D         = 8'h44;
  localparam logic [7:0] KEY_NONE       = 8'hFF;
  localparam logic [7:0] KEY_REQUIRE    = 8'h40;
  localparam logic [7:0] KEY_FORBID     = 8'h80;
  localparam logic [7:0] KEY_SHIFT_DOWN = 8'd39;
  localparam logic [7:0] KEY_SHIFT_UP   = 8'd50;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_OUT,
    MODE_READ,
    MODE_WRITE
  } mode_e;

  function automatic logic [7:0] nib_to_hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding pre-mapped key codes; pointers carry a wrap bit.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  assign dout  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_sys) mem_q <= mem_d;

endmodule

// File: rtl/workboy_link_core.sv
// WorkBoy keyboard/RTC link peripheral: serial bit layer, command decode, key FIFO.
//   mode       | meaning
//   MODE_IDLE  | no session; unknown bytes answered with 0x00
//   MODE_OUT   | every byte runs one key step
//   MODE_READ  | bytes answered with hex nibbles of the buffer
//   MODE_WRITE | 2 header bytes, then BUF_BYTES stored bytes; replies 'D'
module workboy_link_core
  import workboy_pkg::*;
#(
  parameter int KEY_FIFO_DEPTH = 8,
  parameter int BUF_BYTES      = 21,
  parameter int BIT_TIMEOUT    = 65536
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [7:0]                   key_code,
  output logic                         key_ready,
  input  logic [64:0]                  rtc_bcd,
  input  logic                         serial_clk_in,
  input  logic                         serial_data_in,
  output logic                         serial_data_out,
  output logic                         buf_wr_valid,
  output logic [$clog2(BUF_BYTES)-1:0] buf_wr_addr,
  output logic [7:0]                   buf_wr_data,
  output logic                         key_overflow
);
  localparam int AW = $clog2(BUF_BYTES);
  localparam int IW = $clog2(2*BUF_BYTES+1);
  localparam int TW = $clog2(BIT_TIMEOUT);
  localparam logic [IW-1:0] IDX_END     = IW'(2*BUF_BYTES);
  localparam logic [IW-1:0] IDX_LAST_WR = IW'(BUF_BYTES+1);
  localparam logic [TW-1:0] TMR_LOAD    = TW'(BIT_TIMEOUT-1);

  logic          sclk_s_q, sclk_p_q, edge_fall, edge_rise;
  logic          armed_q, armed_d, sdo_q, sdo_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d, tx_q, tx_d, cur_q, cur_d;
  logic [TW-1:0] tmr_q, tmr_d;
  mode_e         mode_q, mode_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sd_q, sd_d, us_q, us_d, ovf_q, ovf_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, wr_idx, rd_idx;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    data_buf_q [BUF_BYTES];
  logic [7:0]    data_buf_d [BUF_BYTES];
  logic [7:0]    byte_in, resp, kc, yr_bin, fifo_dout;
  logic          byte_done, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic          unused_rtc;

  key_fifo #(.DEPTH(KEY_FIFO_DEPTH), .WIDTH(8)) u_key_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (key_code),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Edge detectors keep tracking the line through reset so release never fakes an edge.
  always_ff @(posedge clk_sys) begin
    sclk_s_q <= serial_clk_in;
    sclk_p_q <= sclk_s_q;
  end

  assign edge_fall  = sclk_p_q & ~sclk_s_q;
  assign edge_rise  = ~sclk_p_q & sclk_s_q;
  assign byte_in    = {rx_q[6:0], serial_data_in};
  assign yr_bin     = 8'd100 + 8'd10 * {4'h0, rtc_bcd[47:44]} + {4'h0, rtc_bcd[43:40]};
  assign wr_idx     = AW'(idx_q - IW'(2));
  assign rd_idx     = AW'(idx_q >> 1);
  assign unused_rtc = ^rtc_bcd[64:48];

  always_comb begin
    armed_d    = armed_q;
    sdo_d      = sdo_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    cur_d      = cur_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    sd_d       = sd_q;
    us_d       = us_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    data_buf_d = data_buf_q;
    byte_done  = 1'b0;
    resp       = 8'h00;
    fifo_pop   = 1'b0;
    kc         = cur_q;
    tmr_d      = (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;

    if (edge_fall) begin
      armed_d = 1'b1;
      sdo_d   = tx_q[7];
    end

    if (edge_rise) begin
      tmr_d = TMR_LOAD;
      if (armed_q) begin
        armed_d = 1'b0;
        rx_d    = byte_in;
        if (bit_cnt_q != 3'd7) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          tx_d      = {tx_q[6:0], 1'b0};
        end else begin
          bit_cnt_d = 3'd0;
          byte_done = 1'b1;
        end
      end else begin
        bit_cnt_d = 3'd0;
      end
    end else if (tmr_q == '0 && bit_cnt_q != 3'd0) begin
      bit_cnt_d = 3'd0;
      tx_d      = KEY_NONE;
    end

    if (byte_done) begin
      if (mode_q == MODE_WRITE) begin
        resp = RESP_D;
        if (idx_q >= IW'(2)) begin
          data_buf_d[wr_idx] = byte_in;
          wr_valid_d = 1'b1;
          wr_addr_d  = wr_idx;
          wr_data_d  = byte_in;
        end
        if (idx_q == IDX_LAST_WR) mode_d = MODE_OUT;
        idx_d = idx_q + IW'(1);
      end else if (byte_in == CMD_R) begin
        resp   = RESP_D;
        mode_d = MODE_READ;
        idx_d  = '0;
        cur_d  = KEY_NONE;
        for (int i = 0; i < BUF_BYTES; i++) data_buf_d[i] = 8'h00;
        data_buf_d[0]  = 8'h04;
        data_buf_d[2]  = rtc_bcd[7:0];
        data_buf_d[3]  = rtc_bcd[15:8];
        data_buf_d[4]  = rtc_bcd[23:16];
        data_buf_d[5]  = rtc_bcd[31:24];
        data_buf_d[6]  = rtc_bcd[39:32];
        data_buf_d[15] = yr_bin;
      end else if (byte_in == CMD_W) begin
        resp   = RESP_D;
        mode_d = MODE_WRITE;
        idx_d  = '0;
        cur_d  = KEY_NONE;
      end else if (byte_in == CMD_O || mode_q == MODE_OUT) begin
        mode_d = MODE_OUT;
        // Pull a fresh key and tag it with the shift transition it needs.
        if (cur_q == KEY_NONE && !fifo_empty) begin
          fifo_pop = 1'b1;
          kc       = fifo_dout;
          if (kc[7:6] == 2'b00 && us_q != sd_q) kc = kc | (us_q ? KEY_REQUIRE : KEY_FORBID);
        end
        cur_d = KEY_NONE;
        if (kc == KEY_NONE) begin
          resp = KEY_NONE;
        end else if (kc[6]) begin
          if (sd_q) begin
            resp = kc & ~KEY_REQUIRE;
          end else begin
            resp  = KEY_SHIFT_DOWN;
            sd_d  = 1'b1;
            cur_d = kc & ~KEY_REQUIRE;
          end
        end else if (kc[7]) begin
          if (!sd_q) begin
            resp = kc & ~KEY_FORBID;
          end else begin
            resp  = KEY_SHIFT_UP;
            sd_d  = 1'b0;
            cur_d = kc & ~KEY_FORBID;
          end
        end else begin
          resp = kc;
          if (kc == KEY_SHIFT_DOWN) begin
            sd_d = 1'b1;
            us_d = 1'b1;
          end else if (kc == KEY_SHIFT_UP) begin
            sd_d = 1'b0;
            us_d = 1'b0;
          end
        end
      end else if (mode_q == MODE_READ) begin
        if (idx_q == IDX_END) begin
          resp = 8'h00;
        end else begin
          resp  = nib_to_hex(idx_q[0] ? data_buf_q[rd_idx][3:0] : data_buf_q[rd_idx][7:4]);
          idx_d = idx_q + IW'(1);
        end
      end else begin
        resp = 8'h00;
      end
      tx_d = resp;
    end

    fifo_push = key_valid & (~fifo_full | fifo_pop);
    ovf_d     = ovf_q | (key_valid & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      armed_q    <= 1'b0;
      sdo_q      <= 1'b1;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      cur_q      <= KEY_NONE;
      tmr_q      <= TMR_LOAD;
      mode_q     <= MODE_IDLE;
      idx_q      <= '0;
      sd_q       <= 1'b0;
      us_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < BUF_BYTES; i++) data_buf_q[i] <= 8'h00;
    end else begin
      armed_q    <= armed_d;
      sdo_q      <= sdo_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      cur_q      <= cur_d;
      tmr_q      <= tmr_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      sd_q       <= sd_d;
      us_q       <= us_d;
      ovf_q      <= ovf_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      data_buf_q <= data_buf_d;
    end
  end

  assign key_ready       = ~fifo_full;
  assign key_overflow    = ovf_q;
  assign serial_data_out = sdo_q;
  assign buf_wr_valid    = wr_valid_q;
  assign buf_wr_addr     = wr_addr_q;
  assign buf_wr_data     = wr_data_q;

endmodule

// File: tb/tb_workboy_link_core.sv
// Bench for workboy_link_core: acts as the Game Boy master, scoreboards every returned byte.
module tb_workboy_link_core;
  localparam int DEPTH = 8;
  localparam int NB    = 21;
  localparam int TO    = 200;
  localparam int HALF  = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_ready;
  logic [64:0] rtc_bcd = '0;
  logic        serial_clk_in = 1'b1;
  logic        serial_data_in = 1'b1;
  logic        serial_data_out;
  logic        buf_wr_valid;
  logic [4:0]  buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic        key_overflow;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  logic [7:0]  exp_q[$];
  logic [12:0] wr_exp_q[$];

  typedef struct {
    bit         rst;
    bit         push;
    logic [7:0] key;
    logic [7:0] cmd;
    logic [7:0] resp;
  } vec_t;
  vec_t vecs[14];

  workboy_link_core #(.KEY_FIFO_DEPTH(DEPTH), .BUF_BYTES(NB), .BIT_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .rtc_bcd(rtc_bcd), .serial_clk_in(serial_clk_in),
    .serial_data_in(serial_data_in), .serial_data_out(serial_data_out),
    .buf_wr_valid(buf_wr_valid), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .key_overflow(key_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic shift_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      serial_data_in = b[i];
      serial_clk_in  = 1'b0;
      cycles(HALF);
      got[i] = serial_data_out;
      serial_clk_in = 1'b1;
      cycles(HALF);
    end
  endtask

  // The byte received now answers the previous byte; queue this byte's expected answer.
  task automatic xfer(input logic [7:0] b, input logic [7:0] exp_resp, input string name);
    logic [7:0] got;
    shift_bits(b, 8, got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %0h expected nothing queued", name, got);
    end else begin
      check(name, 32'(got), 32'(exp_q.pop_front()));
    end
    exp_q.push_back(exp_resp);
  endtask

  task automatic push_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_code  = k;
    cycles(1);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(3);
    check("sdo_in_reset", 32'(serial_data_out), 32'd1);
    reset = 1'b0;
    cycles(1);
    check("key_ready_after_reset", 32'(key_ready), 32'd1);
    check("overflow_after_reset", 32'(key_overflow), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h00);
  endtask

  always @(negedge clk_sys) begin
    if (!reset && buf_wr_valid) begin
      wr_seen++;
      if (wr_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL buf_wr: got addr %0d data %0h expected no strobe", buf_wr_addr, buf_wr_data);
      end else begin
        check("buf_wr", 32'({buf_wr_addr, buf_wr_data}), 32'(wr_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] junk;
    logic [7:0] bm [NB];
    logic [7:0] d;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h4F, 8'hFF};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 8'h4F, 8'h11};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h4F, 8'hFF};
    vecs[3]  = '{1'b0, 1'b1, 8'h51, 8'h4F, 8'd39};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h4F, 8'h11};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h4F, 8'hFF};
    vecs[6]  = '{1'b0, 1'b1, 8'h11, 8'h4F, 8'd50};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h4F, 8'h11};
    vecs[8]  = '{1'b0, 1'b1, 8'h27, 8'h4F, 8'h27};
    vecs[9]  = '{1'b0, 1'b1, 8'h91, 8'h4F, 8'd50};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h4F, 8'h11};
    vecs[11] = '{1'b0, 1'b1, 8'h05, 8'h4F, 8'd39};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h4F, 8'h05};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h33, 8'h00};

    cycles(1);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].push) push_key(vecs[i].key);
      xfer(vecs[i].cmd, vecs[i].resp, $sformatf("vec%0d", i));
    end
    xfer(8'h33, 8'h00, "vec_tail");

    // FIFO fill, overflow and in-order drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_key(8'(i + 1));
    check("key_ready_full", 32'(key_ready), 32'd0);
    check("overflow_at_full", 32'(key_overflow), 32'd0);
    push_key(8'h09);
    check("overflow_set", 32'(key_overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) xfer(8'h4F, 8'(i + 1), $sformatf("drain%0d", i));
    xfer(8'h4F, 8'hFF, "drain_empty");
    xfer(8'h00, 8'hFF, "drain_tail");
    check("key_ready_drained", 32'(key_ready), 32'd1);
    check("overflow_sticky", 32'(key_overflow), 32'd1);

    // READ: buffer hex dump
    do_reset();
    rtc_bcd = {17'h0, 8'h24, 8'h09, 8'h31, 8'h12, 8'h34, 8'h56};
    for (int i = 0; i < NB; i++) bm[i] = 8'h00;
    bm[0] = 8'h04; bm[2] = 8'h56; bm[3] = 8'h34; bm[4] = 8'h12; bm[5] = 8'h31; bm[6] = 8'h09;
    bm[15] = 8'h7C;
    xfer(8'h52, 8'h44, "read_cmd");
    for (int k = 0; k < 2*NB; k++) begin
      d = bm[k/2];
      xfer(8'h00, hex_ascii((k % 2 == 1) ? d[3:0] : d[7:4]), $sformatf("read_nib%0d", k));
    end
    xfer(8'h00, 8'h00, "read_end0");
    xfer(8'h00, 8'h00, "read_end1");
    xfer(8'h00, 8'h00, "read_tail");

    // WRITE: headers dropped, data strobed, 'R' stored as data, then OUT
    do_reset();
    wr_seen = 0;
    xfer(8'h57, 8'h44, "write_cmd");
    xfer(8'h11, 8'h44, "write_hdr0");
    xfer(8'h22, 8'h44, "write_hdr1");
    for (int i = 0; i < NB; i++) begin
      d = (i == 3) ? 8'h52 : 8'(8'hA0 + i);
      wr_exp_q.push_back({5'(i), d});
      xfer(d, 8'h44, $sformatf("write_data%0d", i));
    end
    xfer(8'h00, 8'hFF, "write_then_out");
    xfer(8'h00, 8'hFF, "write_tail");
    check("write_strobe_count", 32'(wr_seen), 32'(NB));
    check("write_pending", 32'(wr_exp_q.size()), 32'd0);

    // Timeout mid-byte resynchronises the bit counter
    do_reset();
    shift_bits(8'h00, 3, junk);
    cycles(TO + 20);
    exp_q.delete();
    exp_q.push_back(8'hFF);
    xfer(8'h4F, 8'hFF, "timeout_o");
    xfer(8'h00, 8'hFF, "timeout_out");
    xfer(8'h00, 8'hFF, "timeout_tail");

    // Unarmed rising edge after a mid-byte reset is not sampled
    shift_bits(8'h00, 3, junk);
    serial_clk_in = 1'b0;
    cycles(HALF);
    reset = 1'b1;
    cycles(3);
    check("sdo_in_reset_low_clk", 32'(serial_data_out), 32'd1);
    reset = 1'b0;
    cycles(4);
    serial_clk_in = 1'b1;
    cycles(HALF);
    exp_q.delete();
    exp_q.push_back(8'h00);
    xfer(8'h4F, 8'hFF, "unarmed_o");
    xfer(8'h00, 8'hFF, "unarmed_out");
    xfer(8'h00, 8'hFF, "unarmed_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
